// File: rtl/hub75_scan_driver.sv
// HUB75 row-scan driver: fetches one row of pixel words per scan line, shifts them
// out as a binary-compare PWM plane, latches the row and opens the output-enable window.
module hub75_scan_driver #(
    parameter int  COLS      = 160,
    parameter int  SCAN_ROWS = 20,
    parameter int  DEPTH     = 3,
    parameter int  CHAN      = 2,
    parameter int  ON_TIME   = 64,
    localparam int ROW_W     = $clog2(SCAN_ROWS),
    localparam int ADDR_W    = $clog2(COLS * SCAN_ROWS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [7:0]              i_brightness,
    output logic                    o_rd_en,
    output logic [ADDR_W-1:0]       o_rd_addr,
    input  logic [CHAN*6*DEPTH-1:0] i_rd_data,
    input  logic                    i_swap_req,
    output logic                    o_swap_ack,
    output logic                    o_buf_sel,
    output logic                    o_data_clock,
    output logic                    o_data_latch,
    output logic                    o_data_blank,
    output logic [CHAN-1:0]         o_data_r,
    output logic [CHAN-1:0]         o_data_g,
    output logic [CHAN-1:0]         o_data_b,
    output logic [CHAN-1:0]         o_data_r2,
    output logic [CHAN-1:0]         o_data_g2,
    output logic [CHAN-1:0]         o_data_b2,
    output logic [ROW_W-1:0]        o_row_select,
    output logic                    o_frame_done
);
    localparam int               COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);
    localparam logic [DEPTH-1:0] PWM_MAX  = {DEPTH{1'b1}};
    localparam logic [7:0]       ON_LAST  = 8'(ON_TIME - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SHIFT, S_BLANK, S_LATCH, S_UNLATCH, S_DISPLAY
    } state_t;

    state_t                  state, state_nx;
    logic [COL_W-1:0]        col;
    logic                    phase_b;
    logic [7:0]              disp_cnt;
    logic [ROW_W-1:0]        row;
    logic [DEPTH-1:0]        pwm_cnt;
    logic                    pending;
    logic [ADDR_W-1:0]       row_base;
    logic [CHAN-1:0][5:0]    rgb_p0, rgb_p1, rgb_out;
    logic                    disp_last, row_last;

    function automatic logic pwm_lit(input logic [DEPTH-1:0] level, input logic [DEPTH-1:0] value);
        return level <= value;
    endfunction

    assign row_base  = ADDR_W'(row) * ADDR_W'(COLS);
    assign disp_last = (disp_cnt == ON_LAST);
    assign row_last  = (row == ROW_LAST);

    // Stage p0: compare the word arriving this cycle against the current PWM level
    always_comb begin
        for (int c = 0; c < CHAN; c++)
            for (int k = 0; k < 6; k++)
                rgb_p0[c][k] = pwm_lit(pwm_cnt, i_rd_data[c*6*DEPTH + k*DEPTH +: DEPTH]);
    end

    // Live compare during clock-low cycle, held value during clock-high cycle
    always_comb begin
        rgb_out = (state == S_SHIFT && !phase_b) ? rgb_p0 : rgb_p1;
        for (int c = 0; c < CHAN; c++) begin
            o_data_r[c]  = rgb_out[c][5];
            o_data_g[c]  = rgb_out[c][4];
            o_data_b[c]  = rgb_out[c][3];
            o_data_r2[c] = rgb_out[c][2];
            o_data_g2[c] = rgb_out[c][1];
            o_data_b2[c] = rgb_out[c][0];
        end
    end

    always_comb begin
        state_nx     = state;
        o_rd_en      = 1'b0;
        o_rd_addr    = '0;
        o_data_clock = 1'b0;
        o_data_latch = 1'b0;
        o_data_blank = 1'b1;
        o_frame_done = 1'b0;
        case (state)
            S_IDLE:    if (i_enable) state_nx = S_FETCH;
            S_FETCH: begin
                o_rd_en   = 1'b1;
                o_rd_addr = row_base;
                state_nx  = S_SHIFT;
            end
            S_SHIFT: begin
                if (phase_b) begin
                    o_data_clock = 1'b1;
                    if (col == COL_LAST) begin
                        state_nx = S_BLANK;
                    end else begin
                        o_rd_en   = 1'b1;
                        o_rd_addr = row_base + ADDR_W'(col) + ADDR_W'(1);
                    end
                end
            end
            S_BLANK:   state_nx = S_LATCH;
            S_LATCH: begin
                o_data_latch = 1'b1;
                state_nx     = S_UNLATCH;
            end
            S_UNLATCH: state_nx = S_DISPLAY;
            S_DISPLAY: begin
                o_data_blank = (disp_cnt >= i_brightness);
                if (disp_last) begin
                    o_frame_done = row_last && (pwm_cnt == PWM_MAX);
                    state_nx     = i_enable ? S_FETCH : S_IDLE;
                end
            end
            default:   state_nx = S_IDLE;
        endcase
        o_swap_ack = o_frame_done && (pending || i_swap_req);
    end

    // Stage p1: shift registers, scan counters and buffer ownership
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            col          <= '0;
            phase_b      <= 1'b0;
            disp_cnt     <= '0;
            row          <= '0;
            pwm_cnt      <= DEPTH'(1);
            pending      <= 1'b0;
            o_buf_sel    <= 1'b0;
            o_row_select <= '0;
            rgb_p1       <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: begin
                    col     <= '0;
                    phase_b <= 1'b0;
                end
                S_SHIFT: begin
                    phase_b <= ~phase_b;
                    if (!phase_b)
                        rgb_p1 <= rgb_p0;
                    else if (col != COL_LAST)
                        col <= col + COL_W'(1);
                end
                S_LATCH:   o_row_select <= row;
                S_UNLATCH: disp_cnt <= '0;
                S_DISPLAY: begin
                    disp_cnt <= disp_cnt + 8'd1;
                    if (disp_last) begin
                        if (row_last) begin
                            row     <= '0;
                            pwm_cnt <= (pwm_cnt == PWM_MAX) ? DEPTH'(1) : pwm_cnt + DEPTH'(1);
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (o_swap_ack) begin
                o_buf_sel <= ~o_buf_sel;
                pending   <= 1'b0;
            end else if (i_swap_req) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: doc/hub75_scan_driver.md
HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

Interface
REQ-001 SHALL have parameter COLS, default 160: columns shifted per row.
REQ-002 SHALL have parameter SCAN_ROWS, default 20: row-select values per frame; ROW_W = clog2(SCAN_ROWS).
REQ-003 SHALL have parameter DEPTH, default 3: bits per colour component; PWM levels 1..2^DEPTH-1.
REQ-004 SHALL have parameter CHAN, default 2: parallel panel chains; each RGB output is CHAN bits wide.
REQ-005 SHALL have parameter ON_TIME, default 64 (1..255): display-phase cycles per row.
REQ-006 SHALL have ports: i_clk in 1, system clock; i_rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: i_enable in 1, run/pause; i_brightness in 8, OE-low cycles per row.
REQ-008 SHALL have ports: o_rd_en out 1, buffer read strobe; o_rd_addr out clog2(COLS*SCAN_ROWS), pixel-word address.
REQ-009 SHALL have port i_rd_data in CHAN*6*DEPTH: chain c slice [c*6*DEPTH +: 6*DEPTH] = {R1,G1,B1,R2,G2,B2}, DEPTH bits each, R1 most significant; valid one cycle after address.
REQ-010 SHALL have ports: i_swap_req in 1, buffer-swap request; o_swap_ack out 1, one-cycle swap pulse; o_buf_sel out 1, displayed buffer.
REQ-011 SHALL have ports: o_data_clock, o_data_latch, o_data_blank out 1 each; o_data_r/g/b and o_data_r2/g2/b2 out CHAN each; o_row_select out ROW_W; o_frame_done out 1.

Function
REQ-012 SHALL implement FSM IDLE -> FETCH -> SHIFT -> BLANK -> LATCH -> UNLATCH -> DISPLAY -> (FETCH or IDLE).
REQ-013 IDLE SHALL hold o_data_blank=1, o_data_clock=0; exit to FETCH when i_enable=1.
REQ-014 FETCH (1 cycle) SHALL assert o_rd_en, o_rd_addr = row*COLS + 0.
REQ-015 SHALL spend 2 cycles per column in SHIFT: cycle A clock=0, RGB outputs updated from i_rd_data; cycle B clock=1, next column address issued (none after last column); shift phase = 1 + 2*COLS cycles.
REQ-016 Per chain/half/component, RGB output bit SHALL be 1 iff pwm_cnt <= component value (value 0 never lit, max always lit).
REQ-017 BLANK: o_data_blank=1 one cycle; LATCH: o_data_latch=1, o_row_select <= row just shifted; UNLATCH: o_data_latch=0.
REQ-018 DISPLAY SHALL last ON_TIME cycles; o_data_blank=0 for first min(i_brightness, ON_TIME) cycles, else 1; i_brightness=0 keeps panel dark.
REQ-019 At DISPLAY end: row increments; row SCAN_ROWS-1 wraps to 0 and pwm_cnt increments; pwm_cnt 2^DEPTH-1 wraps to 1 with o_frame_done pulsed one cycle.
REQ-020 i_swap_req=1 SHALL set a pending flag; repeated requests while pending are absorbed.
REQ-021 On the frame_done cycle with pending (or i_swap_req=1 that same cycle), o_buf_sel SHALL toggle, o_swap_ack pulse one cycle, pending cleared; never mid-frame.
REQ-022 i_enable=0 SHALL take effect only at DISPLAY end (-> IDLE, blanked); resumes with the next row, preserving row and pwm_cnt.
REQ-023 o_rd_en SHALL be 0 outside FETCH and SHIFT cycle B.

Reset
REQ-024 i_rst=1 SHALL on next edge force state IDLE, o_data_blank=1, o_data_clock=0, o_data_latch=0, all RGB 0, o_row_select=0, row=0, pwm_cnt=1, o_buf_sel=0, pending=0, o_swap_ack=0, o_frame_done=0, o_rd_en=0, o_rd_addr=0, from any state including mid-shift.

Verification (COLS=4, SCAN_ROWS=2, DEPTH=2, CHAN=1, ON_TIME=4)
REQ-025 Reset with i_enable=1 -> all REQ-024 values; FETCH addr 0 on first cycle after release.
REQ-026 Word with R1=2, others 0 -> o_data_r[0]=1 at pwm_cnt 1,2, 0 at 3; 4 clock rising edges per row; addresses 0-3 row 0, 4-7 row 1.
REQ-027 i_brightness=0 -> o_data_blank never 0; =2 -> exactly 2 low cycles per DISPLAY; =9 -> 4 low cycles.
REQ-028 i_swap_req pulse mid-frame -> o_buf_sel toggles with o_swap_ack exactly on o_frame_done cycle; pulse on frame_done cycle also swaps there.
REQ-029 i_rst mid-SHIFT (column 2) -> next cycle reset values; restart row 0, column 0, pwm_cnt 1.
REQ-030 i_enable=0 during SHIFT -> row completes through DISPLAY, IDLE blanked; re-enable -> next row's FETCH, pwm_cnt unchanged.
